// File: rtl/btb_update_queue_pkg.sv
// ---------------------------------------------------------------------------
// btb_update_queue_pkg
//
// Shared definitions for the BTB update queue.
//   XLEN               : width of PCs and branch targets
//   btb_update_entry_t : one queued BTB write (valid flag, source PC, target)
// ---------------------------------------------------------------------------
package btb_update_queue_pkg;

   localparam int XLEN = 32;

   // One pending BTB write. The source PC is the key used for coalescing.
   typedef struct packed {
      logic            valid;
      logic [XLEN-1:0] source_pc;
      logic [XLEN-1:0] dest_pc;
   } btb_update_entry_t;

endpackage

// File: rtl/btb_update_queue.sv
// ---------------------------------------------------------------------------
// btb_update_queue
//
// Buffers resolved taken branches whose BTB entry is missing or holds the
// wrong target, and drains them one per granted cycle into the BTB's single
// write port. Execute never stalls: updates arriving while the queue is full
// are dropped and counted. A new update for a PC already waiting in the queue
// overwrites that entry's target in place.
//
// Ports:
//   clock, reset          : clock and synchronous active-high reset
//   resolve_*             : resolved branch from execute/complete
//   write_ready           : BTB write port granted this cycle
//   write_enable          : head entry is valid and presented to the BTB
//   write_source_pc/_dest : head entry contents, zero when the queue is empty
//   occupancy             : number of valid entries
//   drop_count            : saturating count of dropped updates
// ---------------------------------------------------------------------------
module btb_update_queue
   import btb_update_queue_pkg::*;
#(
   parameter int DEPTH      = 4,
   parameter int DROP_CNT_W = 8
) (
   input  logic                     clock,
   input  logic                     reset,
   input  logic                     resolve_valid,
   input  logic [XLEN-1:0]          resolve_pc,
   input  logic                     resolve_taken,
   input  logic [XLEN-1:0]          resolve_target,
   input  logic                     resolve_pred_hit,
   input  logic [XLEN-1:0]          resolve_pred_target,
   input  logic                     write_ready,
   output logic                     write_enable,
   output logic [XLEN-1:0]          write_source_pc,
   output logic [XLEN-1:0]          write_dest_pc,
   output logic [$clog2(DEPTH):0]   occupancy,
   output logic [DROP_CNT_W-1:0]    drop_count
);

   localparam int PTR_W = $clog2(DEPTH);
   localparam int OCC_W = PTR_W + 1;

   btb_update_entry_t      entries [DEPTH];
   logic [PTR_W-1:0]       head;
   logic [PTR_W-1:0]       tail;

   logic                   candidate;
   logic                   dequeue;
   logic [DEPTH-1:0]       match;
   logic [PTR_W-1:0]       match_idx;
   logic                   coalesce;
   logic                   enqueue;
   logic                   drop;
   logic                   full;

   // Outputs come straight from the head register and the occupancy count,
   // so nothing on the resolve or grant side reaches them combinationally.
   assign write_enable    = (occupancy != '0);
   assign write_source_pc = write_enable ? entries[head].source_pc : '0;
   assign write_dest_pc   = write_enable ? entries[head].dest_pc   : '0;

   // Only taken branches that missed in the BTB or hit with a stale target
   // need a BTB write.
   assign candidate = resolve_valid & resolve_taken &
                      ~(resolve_pred_hit & (resolve_pred_target == resolve_target));

   assign dequeue = write_enable & write_ready;
   assign full    = (occupancy == OCC_W'(DEPTH));

   // Look for a surviving entry with the same source PC. The head is excluded
   // while it is being written out, so the BTB still sees the old target
   // followed by the new one instead of the update being lost.
   always_comb begin
      match     = '0;
      match_idx = '0;
      for (int i = 0; i < DEPTH; i++) begin
         if (entries[i].valid && (entries[i].source_pc == resolve_pc) &&
             !(dequeue && (head == PTR_W'(i)))) begin
            match[i]  = 1'b1;
            match_idx = PTR_W'(i);
         end
      end
   end

   assign coalesce = candidate & (|match);
   assign enqueue  = candidate & ~coalesce & (~full | dequeue);
   assign drop     = candidate & ~coalesce & full & ~dequeue;

   // Queue storage and pointers. The dequeue invalidation is written before
   // the enqueue so that a full queue reusing the freed head slot in the same
   // cycle ends up with the new entry valid.
   always_ff @(posedge clock) begin
      if (reset) begin
         head      <= '0;
         tail      <= '0;
         occupancy <= '0;
         for (int i = 0; i < DEPTH; i++) begin
            entries[i] <= '0;
         end
      end else begin
         if (dequeue) begin
            entries[head].valid <= 1'b0;
            head                <= head + PTR_W'(1);
         end
         if (coalesce) begin
            entries[match_idx].dest_pc <= resolve_target;
         end
         if (enqueue) begin
            entries[tail] <= '{valid: 1'b1, source_pc: resolve_pc, dest_pc: resolve_target};
            tail          <= tail + PTR_W'(1);
         end
         case ({enqueue, dequeue})
            2'b10:   occupancy <= occupancy + OCC_W'(1);
            2'b01:   occupancy <= occupancy - OCC_W'(1);
            default: occupancy <= occupancy;
         endcase
      end
   end

   // Dropped-update counter, saturating so a long burst never wraps to a
   // misleadingly small value.
   always_ff @(posedge clock) begin
      if (reset) begin
         drop_count <= '0;
      end else if (drop && (drop_count != '1)) begin
         drop_count <= drop_count + DROP_CNT_W'(1);
      end
   end

endmodule

// File: tb/tb_btb_update_queue.sv
// ---------------------------------------------------------------------------
// tb_btb_update_queue
//
// Directed testbench for btb_update_queue with hand-computed expectations.
// ---------------------------------------------------------------------------
module tb_btb_update_queue;
   import btb_update_queue_pkg::*;

   logic              clock;
   logic              reset;
   logic              resolve_valid;
   logic [XLEN-1:0]   resolve_pc;
   logic              resolve_taken;
   logic [XLEN-1:0]   resolve_target;
   logic              resolve_pred_hit;
   logic [XLEN-1:0]   resolve_pred_target;
   logic              write_ready;
   logic              write_enable;
   logic [XLEN-1:0]   write_source_pc;
   logic [XLEN-1:0]   write_dest_pc;
   logic [2:0]        occupancy;
   logic [7:0]        drop_count;

   int checks   = 0;
   int failures = 0;

   btb_update_queue #(.DEPTH(4), .DROP_CNT_W(8)) dut (
      .clock               (clock),
      .reset               (reset),
      .resolve_valid       (resolve_valid),
      .resolve_pc          (resolve_pc),
      .resolve_taken       (resolve_taken),
      .resolve_target      (resolve_target),
      .resolve_pred_hit    (resolve_pred_hit),
      .resolve_pred_target (resolve_pred_target),
      .write_ready         (write_ready),
      .write_enable        (write_enable),
      .write_source_pc     (write_source_pc),
      .write_dest_pc       (write_dest_pc),
      .occupancy           (occupancy),
      .drop_count          (drop_count)
   );

   // 10 ns clock
   initial clock = 1'b0;
   always #5 clock = ~clock;

   // Compare one observed value against its expected value
   task automatic checkOutput(input string tag, input logic [63:0] observed,
                              input logic [63:0] expected);
      checks++;
      if (observed !== expected) begin
         failures++;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
      end
   endtask

   // Present one resolve (or none) plus the grant for a single clock edge,
   // leaving outputs settled 1 ns after the edge
   task automatic applyStimulus(input logic v, input logic [XLEN-1:0] pc,
                                input logic tk, input logic [XLEN-1:0] tgt,
                                input logic ph, input logic [XLEN-1:0] pt,
                                input logic rdy);
      resolve_valid       = v;
      resolve_pc          = pc;
      resolve_taken       = tk;
      resolve_target      = tgt;
      resolve_pred_hit    = ph;
      resolve_pred_target = pt;
      write_ready         = rdy;
      @(posedge clock);
      #1;
      resolve_valid = 1'b0;
   endtask

   // Mispredicted taken branch (BTB miss)
   task automatic mispredict(input logic [XLEN-1:0] pc, input logic [XLEN-1:0] tgt,
                             input logic rdy);
      applyStimulus(1'b1, pc, 1'b1, tgt, 1'b0, '0, rdy);
   endtask

   // Idle cycle with the given grant
   task automatic idle(input logic rdy);
      applyStimulus(1'b0, '0, 1'b0, '0, 1'b0, '0, rdy);
   endtask

   task automatic checkHead(input string tag, input logic [XLEN-1:0] src,
                            input logic [XLEN-1:0] dst);
      checkOutput({tag, ".we"},  64'(write_enable),    64'(1));
      checkOutput({tag, ".src"}, 64'(write_source_pc), 64'(src));
      checkOutput({tag, ".dst"}, 64'(write_dest_pc),   64'(dst));
   endtask

   task automatic checkEmpty(input string tag);
      checkOutput({tag, ".we"},  64'(write_enable),    64'(0));
      checkOutput({tag, ".occ"}, 64'(occupancy),       64'(0));
      checkOutput({tag, ".src"}, 64'(write_source_pc), 64'(0));
      checkOutput({tag, ".dst"}, 64'(write_dest_pc),   64'(0));
   endtask

   initial begin
      reset               = 1'b1;
      resolve_valid       = 1'b0;
      resolve_pc          = '0;
      resolve_taken       = 1'b0;
      resolve_target      = '0;
      resolve_pred_hit    = 1'b0;
      resolve_pred_target = '0;
      write_ready         = 1'b0;

      // Reset state
      idle(1'b0);
      idle(1'b0);
      reset = 1'b0;
      checkEmpty("reset");
      checkOutput("reset.drop", 64'(drop_count), 64'(0));

      // Single update appears the cycle after the resolve, then drains
      mispredict(32'h100, 32'h200, 1'b1);
      checkHead("single", 32'h100, 32'h200);
      checkOutput("single.occ", 64'(occupancy), 64'(1));
      idle(1'b1);
      checkEmpty("single_drained");

      // Filtering: correct taken prediction and not-taken produce nothing
      applyStimulus(1'b1, 32'h104, 1'b1, 32'h300, 1'b1, 32'h300, 1'b0);
      checkOutput("filter_hit.occ", 64'(occupancy), 64'(0));
      applyStimulus(1'b1, 32'h108, 1'b0, 32'h500, 1'b0, 32'h0, 1'b0);
      checkOutput("filter_nt.occ", 64'(occupancy), 64'(0));
      checkOutput("filter.drop", 64'(drop_count), 64'(0));
      // Taken hit with stale target is a candidate
      applyStimulus(1'b1, 32'h10C, 1'b1, 32'h600, 1'b1, 32'h604, 1'b0);
      checkOutput("stale_hit.occ", 64'(occupancy), 64'(1));
      checkHead("stale_hit", 32'h10C, 32'h600);
      idle(1'b1);
      checkEmpty("stale_drained");

      // Coalesce into a non-head-racing entry
      mispredict(32'h100, 32'h200, 1'b0);
      mispredict(32'h110, 32'h210, 1'b0);
      mispredict(32'h100, 32'h400, 1'b0);
      checkOutput("coalesce.occ", 64'(occupancy), 64'(2));
      checkHead("coalesce_h0", 32'h100, 32'h400);
      idle(1'b1);
      checkHead("coalesce_h1", 32'h110, 32'h210);
      idle(1'b1);
      checkEmpty("coalesce_drained");

      // Full and drop
      mispredict(32'h100, 32'h1100, 1'b0);
      mispredict(32'h110, 32'h1110, 1'b0);
      mispredict(32'h120, 32'h1120, 1'b0);
      mispredict(32'h130, 32'h1130, 1'b0);
      mispredict(32'h140, 32'h1140, 1'b0);
      checkOutput("full.occ", 64'(occupancy), 64'(4));
      checkOutput("full.drop", 64'(drop_count), 64'(1));
      checkHead("full_head", 32'h100, 32'h1100);
      // Enqueue while full with a same-cycle dequeue is accepted
      mispredict(32'h150, 32'h1150, 1'b1);
      checkOutput("full_swap.occ", 64'(occupancy), 64'(4));
      checkOutput("full_swap.drop", 64'(drop_count), 64'(1));
      checkHead("drain0", 32'h110, 32'h1110);
      idle(1'b1);
      checkHead("drain1", 32'h120, 32'h1120);
      idle(1'b1);
      checkHead("drain2", 32'h130, 32'h1130);
      idle(1'b1);
      checkHead("drain3", 32'h150, 32'h1150);
      idle(1'b1);
      checkEmpty("full_drained");

      // Head race: matching head is leaving, so the update is re-enqueued
      mispredict(32'h100, 32'h200, 1'b0);
      checkHead("race_before", 32'h100, 32'h200);
      mispredict(32'h100, 32'h500, 1'b1);
      checkOutput("race.occ", 64'(occupancy), 64'(1));
      checkHead("race_after", 32'h100, 32'h500);
      idle(1'b1);
      checkEmpty("race_drained");

      // Reset mid-operation with a candidate present
      mispredict(32'h200, 32'h300, 1'b0);
      mispredict(32'h204, 32'h304, 1'b0);
      mispredict(32'h208, 32'h308, 1'b0);
      checkOutput("prereset.occ", 64'(occupancy), 64'(3));
      reset = 1'b1;
      mispredict(32'h20C, 32'h30C, 1'b1);
      reset = 1'b0;
      checkEmpty("midreset");
      checkOutput("midreset.drop", 64'(drop_count), 64'(0));

      // Wrap-around: stream 10 entries with the port always granted
      for (int i = 0; i < 10; i++) begin
         mispredict(32'h1000 + 32'(i * 4), 32'h2000 + 32'(i), 1'b1);
         checkHead($sformatf("wrap%0d", i), 32'h1000 + 32'(i * 4), 32'h2000 + 32'(i));
         checkOutput($sformatf("wrap%0d.occ", i), 64'(occupancy), 64'(1));
      end
      idle(1'b1);
      checkEmpty("wrap_drained");

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
